mux_arb_nto1_reg: RTL and testbench

Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. The select source is run-time selectable: an external index (classic mux mode) or an internal round-robin arbiter. It merges producers into one registered consumer stream, for example writeback sources or predictor update requests in the pipelined core. One output register stage gives 1-cycle latency and full throughput.

---
 rtl/mux_arb_nto1_reg.sv | 95 +++++++++
 tb/tb_mux_arb_nto1_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1_reg.sv
// N-input registered multiplexer with per-channel valid/ready handshake.
// Select source is an external index (i_mode=0) or an internal round-robin arbiter (i_mode=1).
module mux_arb_nto1_reg #(
  parameter  int NUM_IN = 4,
  parameter  int WIDTH  = 32,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_IN-1:0]       i_valid,
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  output logic [NUM_IN-1:0]       o_ready,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  output logic                    o_valid,
  output logic [WIDTH-1:0]        o_data,
  output logic [SEL_W-1:0]        o_src,
  input  logic                    i_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src;
  logic [SEL_W-1:0] r_ptr;

  logic             w_load_en;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [SEL_W-1:0] w_rr_idx;
  logic [WIDTH-1:0] w_gnt_data;

  // The output register may load whenever it is empty or being drained this cycle.
  assign w_load_en = ~r_valid | i_ready;

  // NOTE: every signal written in a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = '0;
    if (!i_mode) begin
      // Only in-range indices can match, so an out-of-range i_sel never grants.
      for (int k = 0; k < NUM_IN; k++) begin
        if (i_sel == SEL_W'(k) && i_valid[k]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SEL_W'(k);
        end
      end
    end else begin
      // Search from ptr+1 upward with wrap; the last winner is visited last.
      for (int j = 1; j <= NUM_IN; j++) begin
        w_rr_idx = SEL_W'((int'(r_ptr) + j) % NUM_IN);
        if (!w_gnt_vld && i_valid[w_rr_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_rr_idx;
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_gnt_idx == SEL_W'(k)) w_gnt_data = i_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      o_ready[k] = w_load_en & w_gnt_vld & (w_gnt_idx == SEL_W'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= SEL_W'(NUM_IN - 1);
    end else if (w_load_en) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data <= w_gnt_data;
        r_src  <= w_gnt_idx;
        if (i_mode) r_ptr <= w_gnt_idx;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_src   = r_src;

endmodule

// File: tb/tb_mux_arb_nto1_reg.sv
// Self-checking bench for mux_arb_nto1_reg: directed vector table, hand sequences
// for backpressure / mode switch / mid-stream reset, and randomized traffic against a reference model.
module tb_mux_arb_nto1_reg;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 32;
  localparam int SEL_W  = 2;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic [NUM_IN-1:0]       i_valid;
  logic [NUM_IN*WIDTH-1:0] i_data;
  logic [NUM_IN-1:0]       o_ready;
  logic                    i_mode;
  logic [SEL_W-1:0]        i_sel;
  logic                    o_valid;
  logic [WIDTH-1:0]        o_data;
  logic [SEL_W-1:0]        o_src;
  logic                    i_ready;

  mux_arb_nto1_reg #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_sel   (i_sel),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_src   (o_src),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: what the output register and arbiter pointer should hold.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_ptr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Grant chosen by the selection rules; -1 means no channel is granted.
  function automatic int model_grant(input logic mode, input int sel, input logic [NUM_IN-1:0] vld, input int ptr);
    if (!mode) return (sel < NUM_IN && vld[sel]) ? sel : -1;
    for (int n = 1; n <= NUM_IN; n++) begin
      if (vld[(ptr + n) % NUM_IN]) return (ptr + n) % NUM_IN;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_ptr   = NUM_IN - 1;
  endtask

  function automatic logic [NUM_IN*WIDTH-1:0] fixed_data();
    logic [NUM_IN*WIDTH-1:0] d;
    for (int k = 0; k < NUM_IN; k++) d[k*WIDTH +: WIDTH] = WIDTH'(32'hA0 + k);
    return d;
  endfunction

  // One clock cycle: drive at posedge+1, check o_ready mid-cycle, check register after the edge.
  task automatic run_cycle(input logic mode, input logic [SEL_W-1:0] sel, input logic [NUM_IN-1:0] vld,
                           input logic rdy, input string tag, output logic [NUM_IN-1:0] got_rdy);
    logic              load_en;
    int                g;
    logic [NUM_IN-1:0] exp_rdy;
    i_mode  = mode;
    i_sel   = sel;
    i_valid = vld;
    i_ready = rdy;
    #1;
    load_en = !m_valid || rdy;
    g       = model_grant(mode, int'(sel), vld, m_ptr);
    exp_rdy = (load_en && g >= 0) ? NUM_IN'(1 << g) : '0;
    got_rdy = o_ready;
    check({tag, ".ready"}, 64'(o_ready), 64'(exp_rdy));
    if (load_en) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_data = i_data[g*WIDTH +: WIDTH];
        m_src  = g;
        if (mode) m_ptr = g;
      end
    end
    @(posedge i_clk);
    #1;
    check({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
    check({tag, ".data"},  64'(o_data),  64'(m_data));
    check({tag, ".src"},   64'(o_src),   64'(m_src));
  endtask

  typedef struct {
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic [NUM_IN-1:0] vld;
    logic              rdy;
    logic [NUM_IN-1:0] exp_ordy;
    logic              exp_v;
    logic [SEL_W-1:0]  exp_src;
    logic [WIDTH-1:0]  exp_data;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [NUM_IN-1:0] r;

    // Rows run in order straight out of reset (ptr = 3, output empty).
    vecs[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
    vecs[2]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    vecs[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    vecs[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[9]  = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3};
    vecs[10] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[11] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
    vecs[12] = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1};
    vecs[13] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hA1};

    i_rst_n = 1'b0;
    i_valid = '0;
    i_data  = fixed_data();
    i_mode  = 1'b0;
    i_sel   = '0;
    i_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("reset.valid", 64'(o_valid), 64'd0);
    check("reset.data",  64'(o_data),  64'd0);
    check("reset.src",   64'(o_src),   64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      run_cycle(vecs[i].mode, vecs[i].sel, vecs[i].vld, vecs[i].rdy, $sformatf("vec%0d", i), r);
      check($sformatf("vec%0d.tbl_ready", i), 64'(r),       64'(vecs[i].exp_ordy));
      check($sformatf("vec%0d.tbl_valid", i), 64'(o_valid), 64'(vecs[i].exp_v));
      check($sformatf("vec%0d.tbl_src", i),   64'(o_src),   64'(vecs[i].exp_src));
      check($sformatf("vec%0d.tbl_data", i),  64'(o_data),  64'(vecs[i].exp_data));
    end

    // Backpressure: load 0xA1, stall three cycles with everything valid, then release with channel 3.
    run_cycle(1'b0, 2'd1, 4'b0010, 1'b1, "bp_load", r);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 2'd0, 4'b1111, 1'b0, $sformatf("bp_stall%0d", i), r);
      check("bp.ready_zero", 64'(r),      64'd0);
      check("bp.data_hold",  64'(o_data), 64'hA1);
      check("bp.src_hold",   64'(o_src),  64'd1);
    end
    run_cycle(1'b0, 2'd3, 4'b1000, 1'b1, "bp_release", r);
    check("bp.release_ready", 64'(r),      64'b1000);
    check("bp.release_data",  64'(o_data), 64'hA3);

    // Mode switch: ptr=0 from round-robin, two mode-0 transfers of channel 0, then round-robin picks 1.
    run_cycle(1'b1, 2'd0, 4'b0001, 1'b1, "ms_rr0", r);
    run_cycle(1'b0, 2'd0, 4'b1111, 1'b1, "ms_sel0a", r);
    run_cycle(1'b0, 2'd0, 4'b1111, 1'b1, "ms_sel0b", r);
    run_cycle(1'b1, 2'd0, 4'b1111, 1'b1, "ms_rr1", r);
    check("ms.rr_ready", 64'(r),     64'b0010);
    check("ms.rr_src",   64'(o_src), 64'd1);

    // Mid-stream reset: o_valid is 1 here; reset must clear outputs without waiting for a clock edge.
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid.valid", 64'(o_valid), 64'd0);
    check("rst_mid.data",  64'(o_data),  64'd0);
    check("rst_mid.src",   64'(o_src),   64'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    run_cycle(1'b1, 2'd0, 4'b0000, 1'b1, "idle0", r);
    run_cycle(1'b1, 2'd0, 4'b0000, 1'b0, "idle1", r);
    check("idle.valid", 64'(o_valid), 64'd0);
    run_cycle(1'b1, 2'd0, 4'b1111, 1'b1, "rst_ptr", r);
    check("rst_ptr.src", 64'(o_src), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NUM_IN; k++) i_data[k*WIDTH +: WIDTH] = $urandom;
      run_cycle(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, NUM_IN - 1)),
                NUM_IN'($urandom), ($urandom_range(0, 3) != 0), "rand", r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
